// File: rtl/uart_pkg.sv
// Shared definitions for the UART slice: register word addresses, STATUS and
// CONTROL bit positions, FSM state encodings and the baud divisor clamp.
package uart_pkg;

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_TX_DATA  = 4'd4;
  localparam logic [3:0] ADDR_RX_DATA  = 4'd5;
  localparam logic [3:0] ADDR_CONTROL  = 4'd7;
  localparam logic [3:0] ADDR_BAUD_DIV = 4'd9;

  localparam int unsigned ST_TX_BUSY     = 0;
  localparam int unsigned ST_RX_VALID    = 1;
  localparam int unsigned ST_RX_OVERRUN  = 2;
  localparam int unsigned ST_RX_FRAME_ERR = 3;

  localparam int unsigned CTRL_RX_ACK = 29;
  localparam int unsigned CTRL_TX_GO  = 30;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Divisors below MIN_DIV would leave no room for a half-bit start sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser on the serial line plus the 8N1
// receive FSM. Emits a one-cycle done pulse with the received byte and the
// stop-bit error flag; status bookkeeping lives in the register file.
//   clk, reset  : clock, async active-high reset
//   baud_div    : clocks per bit, latched at each frame start
//   rx          : asynchronous serial input, idle high
//   done        : one-cycle pulse at the stop-bit sample
//   data        : received byte, valid with done
//   frame_err   : stop bit sampled low, valid with done
module uart_receiver
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_div,
  input  logic        rx,
  output logic        done,
  output logic [7:0]  data,
  output logic        frame_err
);

  logic        sync1, sync2, rx_prev;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [15:0] div_l;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      div_l     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      done      <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      done    <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !sync2) begin
            div_l <= clamp_div(baud_div);
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          // Resample mid start bit; a high line here was a glitch.
          if (cnt == {1'b0, div_l[15:1]} - 16'd1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == div_l - 16'd1) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == div_l - 16'd1) begin
            cnt       <= '0;
            done      <= 1'b1;
            data      <= shift;
            frame_err <= ~sync2;
            state     <= RX_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: register file, transmit FSM and an instance of
// uart_receiver. RX and TX run independently, each latching BAUD_DIV at
// the start of its own frame.
//   clk, reset : clock, async active-high reset
//   write      : register write strobe
//   addr       : word register address
//   data_in    : write data
//   data_out   : combinational read of register at addr (unmapped -> 0)
//   rx         : serial input, idle high
//   tx         : serial output, idle high
module uart
  import uart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        rx,
  output logic        tx
);

  logic [7:0]  tx_data;
  logic [7:0]  rx_data;
  logic [15:0] baud_div;
  logic        rx_valid, rx_overrun, rx_frame_err;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  logic        rx_done, rx_byte_err;
  logic [7:0]  rx_byte;

  logic ctrl_wr, tx_go, rx_ack, tx_busy;
  logic unused_data_in;

  assign ctrl_wr        = write && (addr == ADDR_CONTROL);
  assign tx_go          = ctrl_wr && data_in[CTRL_TX_GO];
  assign rx_ack         = ctrl_wr && data_in[CTRL_RX_ACK];
  assign tx_busy        = (tx_state != TX_IDLE);
  assign unused_data_in = ^{data_in[31], data_in[28:16]};

  uart_receiver u_rx (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .rx       (rx),
    .done     (rx_done),
    .data     (rx_byte),
    .frame_err(rx_byte_err)
  );

  // Register file and receive status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data      <= '0;
      rx_data      <= '0;
      baud_div     <= 16'(DEFAULT_DIV);
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (write && addr == ADDR_TX_DATA)  tx_data  <= data_in[7:0];
      if (write && addr == ADDR_BAUD_DIV) baud_div <= data_in[15:0];
      // An ack clears the old status first, so a byte completing in the
      // same cycle is reported as fresh rather than as an overrun.
      if (rx_done) begin
        rx_data      <= rx_byte;
        rx_valid     <= 1'b1;
        rx_overrun   <= (rx_overrun | rx_valid) & ~rx_ack;
        rx_frame_err <= (rx_frame_err & ~rx_ack) | rx_byte_err;
      end else if (rx_ack) begin
        rx_valid     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
    end
  end

  // Transmit FSM; tx is a registered output driven straight from here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_go) begin
            tx_div   <= clamp_div(baud_div);
            tx_shift <= tx_data;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == tx_div - 16'd1) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_STATUS: begin
        data_out[ST_TX_BUSY]      = tx_busy;
        data_out[ST_RX_VALID]     = rx_valid;
        data_out[ST_RX_OVERRUN]   = rx_overrun;
        data_out[ST_RX_FRAME_ERR] = rx_frame_err;
      end
      ADDR_TX_DATA:  data_out[7:0]  = tx_data;
      ADDR_RX_DATA:  data_out[7:0]  = rx_data;
      ADDR_BAUD_DIV: data_out[15:0] = baud_div;
      default:       data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Bench for uart: instance A transmits into instance B's receiver (or the
// bench drives B's line directly). Expected received bytes are queued when
// a frame is launched and popped when B reports rx_valid.
module tb_uart;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, write_a, write_b;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic [31:0] dout_a, dout_b;
  logic        tx_a, tx_b, rx_b;
  logic        line_sel, tb_line;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  assign rx_b = line_sel ? tb_line : tx_a;

  uart #(.DEFAULT_DIV(868)) dut_a (
    .clk(clk), .reset(rst_a), .write(write_a), .addr(addr),
    .data_in(data_in), .data_out(dout_a), .rx(tx_b), .tx(tx_a)
  );

  uart #(.DEFAULT_DIV(868)) dut_b (
    .clk(clk), .reset(rst_b), .write(write_b), .addr(addr),
    .data_in(data_in), .data_out(dout_b), .rx(rx_b), .tx(tx_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic which, input logic [3:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    if (which) write_b = 1'b1; else write_a = 1'b1;
    tick(1);
    write_a = 1'b0;
    write_b = 1'b0;
  endtask

  task automatic rd(input logic which, input logic [3:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = which ? dout_b : dout_a;
  endtask

  // Expected tx level n clocks after the TX_GO edge for an 8N1 frame.
  function automatic logic exp_tx(input int n, input int div, input logic [7:0] b);
    int k;
    if (n < div) return 1'b0;
    if (n >= 9 * div) return 1'b1;
    k = n / div - 1;
    return b[k[2:0]];
  endfunction

  // Waits (bounded) for A to finish its frame; returns clocks waited.
  task automatic wait_tx_idle(output int unsigned waited);
    logic [31:0] s;
    waited = 0;
    rd(1'b0, 4'd0, s);
    while (s[0] && waited < 30000) begin
      tick(1);
      waited++;
      rd(1'b0, 4'd0, s);
    end
  endtask

  // Waits for B's rx_valid, checks STATUS and pops the scoreboard; only the
  // most recent expected byte should remain in RX_DATA.
  task automatic check_rx(input string tag, input logic [31:0] exp_status, input int unsigned n_exp);
    logic [31:0] s;
    logic [7:0]  e;
    int unsigned k;
    e = 8'h00;
    k = 0;
    rd(1'b1, 4'd0, s);
    while (!s[1] && k < 30000) begin
      tick(1);
      k++;
      rd(1'b1, 4'd0, s);
    end
    check_val({tag, "_status"}, s, exp_status);
    check_val({tag, "_sb_depth"}, exp_q.size(), n_exp);
    while (exp_q.size() > 0) e = exp_q.pop_front();
    rd(1'b1, 4'd5, s);
    check_val({tag, "_data"}, s, {24'h0, e});
  endtask

  task automatic ack_b(input string tag);
    logic [31:0] s;
    wr(1'b1, 4'd7, 32'h2000_0000);
    rd(1'b1, 4'd0, s);
    check_val({tag, "_ack_status"}, s, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic        busy_gap;
    int unsigned w;
    logic [7:0]  fb;

    rst_a = 1'b1; rst_b = 1'b1; write_a = 1'b0; write_b = 1'b0;
    addr = '0; data_in = '0; line_sel = 1'b0; tb_line = 1'b1;
    tick(3);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);

    // Reset state and register map basics
    rd(1'b0, 4'd9, s); check_val("rst_baud", s, 32'd868);
    rd(1'b0, 4'd0, s); check_val("rst_status", s, 32'h0);
    check_val("rst_tx", {31'h0, tx_a}, 32'h1);
    rd(1'b0, 4'd4, s); check_val("rst_tx_data", s, 32'h0);
    rd(1'b0, 4'd5, s); check_val("rst_rx_data", s, 32'h0);
    wr(1'b0, 4'd5, 32'hFF); rd(1'b0, 4'd5, s); check_val("ro_rx_data", s, 32'h0);
    wr(1'b0, 4'd3, 32'h1234); rd(1'b0, 4'd3, s); check_val("unmapped", s, 32'h0);
    wr(1'b0, 4'd7, 32'h0); rd(1'b0, 4'd7, s); check_val("control_reads0", s, 32'h0);

    // Frame waveform, div 1024, byte 0x05
    wr(1'b0, 4'd9, 32'd1024);
    wr(1'b1, 4'd9, 32'd1024);
    wr(1'b0, 4'd4, 32'h5);
    rd(1'b0, 4'd4, s); check_val("tx_data_rw", s, 32'h5);
    wr(1'b0, 4'd7, 32'h4000_0000);
    exp_q.push_back(8'h05);
    busy_gap = 1'b0;
    for (int n = 0; n <= 10240; n++) begin
      rd(1'b0, 4'd0, s);
      if (n < 10240 && !s[0]) busy_gap = 1'b1;
      if (n == 0 || n == 1023 || n == 1024 || n == 10239 || (n > 1024 && n % 1024 == 512))
        check_val($sformatf("tx_wave_%0d", n), {31'h0, tx_a}, {31'h0, exp_tx(n, 1024, 8'h05)});
      if (n == 10240) begin
        check_val("tx_idle_end", {31'h0, tx_a}, 32'h1);
        check_val("busy_end", s, 32'h0);
      end
      if (n < 10240) tick(1);
    end
    check_val("busy_held", {31'h0, busy_gap}, 32'h0);
    check_rx("rx_05", 32'h2, 1);
    ack_b("rx_05");

    // Loopback 0xA5
    wr(1'b0, 4'd4, 32'hA5);
    wr(1'b0, 4'd7, 32'h4000_0000);
    exp_q.push_back(8'hA5);
    wait_tx_idle(w);
    check_rx("rx_a5", 32'h2, 1);
    ack_b("rx_a5");

    // Overrun: two bytes without ack, div 64
    wr(1'b0, 4'd9, 32'd64);
    wr(1'b1, 4'd9, 32'd64);
    wr(1'b0, 4'd4, 32'h3C);
    wr(1'b0, 4'd7, 32'h4000_0000);
    exp_q.push_back(8'h3C);
    wait_tx_idle(w);
    wr(1'b0, 4'd4, 32'hC3);
    wr(1'b0, 4'd7, 32'h4000_0000);
    exp_q.push_back(8'hC3);
    wait_tx_idle(w);
    tick(10);
    check_rx("overrun", 32'h6, 2);
    ack_b("overrun");

    // Start-bit glitch, div 1024
    line_sel = 1'b1;
    tb_line  = 1'b1;
    wr(1'b1, 4'd9, 32'd1024);
    tick(5);
    tb_line = 1'b0;
    tick(100);
    tb_line = 1'b1;
    tick(2000);
    rd(1'b1, 4'd0, s); check_val("glitch_status", s, 32'h0);
    rd(1'b1, 4'd5, s); check_val("glitch_rx_data", s, 32'hC3);

    // Stop bit forced low, div 64: byte still stored, frame error flagged
    wr(1'b1, 4'd9, 32'd64);
    tick(5);
    fb = 8'h96;
    tb_line = 1'b0; tick(64);
    for (int i = 0; i < 8; i++) begin
      tb_line = fb[i];
      tick(64);
    end
    tb_line = 1'b0; tick(64);
    tb_line = 1'b1;
    exp_q.push_back(8'h96);
    check_rx("frame_err", 32'hA, 1);
    ack_b("frame_err");
    line_sel = 1'b0;
    tick(5);

    // TX_GO and TX_DATA write while busy leave the in-flight frame alone
    wr(1'b0, 4'd4, 32'h5A);
    wr(1'b0, 4'd7, 32'h4000_0000);
    exp_q.push_back(8'h5A);
    tick(100);
    wr(1'b0, 4'd4, 32'hFF);
    wr(1'b0, 4'd7, 32'h4000_0000);
    rd(1'b0, 4'd4, s); check_val("tx_data_midframe", s, 32'hFF);
    wait_tx_idle(w);
    check_val("busy_len_go_ignored", w + 102, 32'd640);
    check_rx("rx_5a", 32'h2, 1);
    ack_b("rx_5a");

    // Divisor below 4 is treated as 4: 40-clock frame
    wr(1'b0, 4'd9, 32'd2);
    rd(1'b0, 4'd9, s); check_val("baud_rw", s, 32'd2);
    wr(1'b0, 4'd7, 32'h4000_0000);
    wait_tx_idle(w);
    check_val("busy_len_clamped", w, 32'd40);

    // Reset mid-transmit
    wr(1'b0, 4'd9, 32'd64);
    wr(1'b0, 4'd7, 32'h4000_0000);
    tick(200);
    rd(1'b0, 4'd0, s); check_val("busy_before_rst", s, 32'h1);
    check_val("tx_before_rst", {31'h0, tx_a}, {31'h0, exp_tx(201, 64, 8'hFF)});
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check_val("rst_async_tx", {31'h0, tx_a}, 32'h1);
    rd(1'b0, 4'd0, s); check_val("rst_async_status", s, 32'h0);
    tick(2);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);
    rd(1'b0, 4'd9, s); check_val("rst_baud_again", s, 32'd868);
    rd(1'b1, 4'd0, s); check_val("rst_b_status", s, 32'h0);
    tick(300);
    check_val("tx_after_rst", {31'h0, tx_a}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter DEFAULT_DIV, default 868, reset value of BAUD_DIV in clocks per bit.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 write  input  1  register write strobe; data_in captured into register at addr on a clk edge while high.
REQ-005 addr  input  4  word register address.
REQ-006 data_in  input  32  write data.
REQ-007 data_out  output  32  combinational read of register at addr; unmapped addresses read 0.
REQ-008 rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-009 tx  output  1  serial transmit line, idle high.

Function
REQ-010 Register map: 0 STATUS (RO), 4 TX_DATA [7:0] (RW), 5 RX_DATA [7:0] (RO), 7 CONTROL (WO, reads 0), 9 BAUD_DIV [15:0] (RW); writes to RO/unmapped addresses ignored.
REQ-011 STATUS bits: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] rx_frame_error; others 0.
REQ-012 CONTROL bit 30 = TX_GO: write with bit 30 set while tx idle starts a frame from current TX_DATA; ignored while tx_busy.
REQ-013 CONTROL bit 29 = RX_ACK: write with bit 29 set clears rx_valid, rx_overrun, rx_frame_error; same-cycle new byte completion wins (sets rx_valid).
REQ-014 Frame format 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BAUD_DIV clocks.
REQ-015 BAUD_DIV is latched at frame start (tx and rx independently); mid-frame writes affect only the next frame; values below 4 are treated as 4.
REQ-016 TX FSM states IDLE, START, DATA, STOP; tx_busy high from the cycle after accepted TX_GO until the final stop-bit clock completes; tx goes low the cycle after TX_GO.
REQ-017 TX_DATA writes during a frame update the register but not the in-flight shift register.
REQ-018 rx passes through a 2-flop synchroniser before use.
REQ-019 RX FSM states IDLE, START, DATA, STOP: falling edge in IDLE starts; start bit resampled at BAUD_DIV/2 clocks, returns to IDLE if high (glitch rejection); data and stop sampled every BAUD_DIV clocks thereafter.
REQ-020 On stop sample: RX_DATA loaded, rx_valid set; rx_frame_error set if stop bit sampled 0 (byte still stored); rx_overrun set if rx_valid was already set.
REQ-021 RX and TX operate concurrently and independently.

Reset
REQ-022 Reset: tx=1, all FSMs IDLE, STATUS bits 0, TX_DATA=0, RX_DATA=0, BAUD_DIV=DEFAULT_DIV, counters 0, synchroniser flops 1.
REQ-023 Reset asserted mid-frame aborts the frame immediately; tx returns high asynchronously.

Structure
REQ-024 Shared package uart_pkg holds register address constants, STATUS/CONTROL bit indices, FSM state enums.
REQ-025 One sub-module uart_receiver (synchroniser + RX FSM); TX FSM and register file inline in uart.

Verification
REQ-026 Reset, read addr 9 -> 868; read addr 0 -> 0; tx=1.
REQ-027 Write addr4=5, addr9=1024, addr7=0x40000000 -> tx low 1024 clocks, then bits 1,0,1,0,0,0,0,0 each 1024 clocks, stop high; STATUS[0] high throughout, low after 10240 clocks.
REQ-028 Loop tx->rx of a second instance with div 1024, send 0xA5 -> receiver STATUS[1]=1, addr5 reads 0xA5; write addr7=0x20000000 -> STATUS reads 0.
REQ-029 Send two bytes without RX_ACK -> STATUS[2]=1, RX_DATA = second byte.
REQ-030 Drive rx low 100 clocks with div 1024 -> no byte received; stop bit forced 0 -> STATUS[3]=1.
REQ-031 Assert reset mid-transmit -> tx=1, STATUS=0 immediately; TX_GO while busy -> frame unchanged.
